// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the Xoodyak response collector.
// Checker build option: XOOD_RESP_TAGCHK_EN.
package xoodyak_pkg;

    localparam int unsigned TAG_W  = 128;
    localparam int unsigned KIND_W = 2;

    typedef enum logic [1:0] {
        KIND_TEXT = 2'd0,
        KIND_TAG  = 2'd1,
        KIND_KEY  = 2'd2
    } kind_e;

    localparam logic [3:0] OP_CRYPT   = 4'd4;
    localparam logic [3:0] OP_DECRYPT = 4'd5;
    localparam logic [3:0] OP_SQUEEZE = 4'd6;
    localparam logic [3:0] OP_SQZKEY  = 4'd8;

    typedef logic [1:0] tstate_t;
    localparam tstate_t T_IDLE  = 2'd0;
    localparam tstate_t T_ARMED = 2'd1;
    localparam tstate_t T_DONE  = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [KIND_W-1:0] kind;
    } dec_t;

    // Map the low opmode nibble to a queue kind; unknown codes are not queued.
    function automatic dec_t decode_op(input logic [3:0] op);
        dec_t d;
        d.valid = 1'b1;
        d.kind  = KIND_TEXT;
        case (op)
            OP_CRYPT, OP_DECRYPT: d.kind = KIND_TEXT;
            OP_SQUEEZE:           d.kind = KIND_TAG;
            OP_SQZKEY:            d.kind = KIND_KEY;
            default:              d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/xoodyak_resp_collect_if.sv
// Core-result input and host-side output handshake of the response collector.
interface xoodyak_resp_collect_if #(
    parameter int unsigned TW = 192
);
    logic          core_valid;
    logic [4:0]    core_opmode;
    logic [TW-1:0] core_text;
    logic          out_ready;
    logic          out_valid;
    logic [TW-1:0] out_data;
    logic [1:0]    out_kind;

    modport master (
        output core_valid, core_opmode, core_text, out_ready,
        input  out_valid, out_data, out_kind
    );

    modport slave (
        input  core_valid, core_opmode, core_text, out_ready,
        output out_valid, out_data, out_kind
    );
endinterface

// File: rtl/xoodyak_resp_fifo.sv
// Result FIFO with a registered head: a write into an empty FIFO shows up one cycle later.
module xoodyak_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned EW    = 194
) (
    input  logic          eph1,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [EW-1:0] wr_data,
    input  logic          rd_en,
    output logic          full_c,
    output logic          rd_valid,
    output logic [EW-1:0] rd_data
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [EW-1:0] head_q, head_d;
    logic          valid_q, valid_d;

    assign full_c   = (cnt_q == CW'(DEPTH));
    assign rd_valid = valid_q;
    assign rd_data  = head_q;

    // Head is read from the post-write array so a same-cycle write to the new head slot is seen.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_en && rd_en) begin
            cnt_d = cnt_q - CW'(1);
        end
        valid_d = (cnt_d != '0);
        head_d  = mem_d[rd_ptr_d];
    end

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/xoodyak_resp_collect.sv
// Collects Xoodyak core results into a kind-tagged FIFO with sticky overflow.
// Optional tag checker compiled in with XOOD_RESP_TAGCHK_EN.
module xoodyak_resp_collect
    import xoodyak_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = 192
) (
    input  logic                  eph1,
    input  logic                  reset,
    xoodyak_resp_collect_if.slave bus,
    input  logic [TAG_W-1:0]      tag_exp,
    input  logic                  tag_load,
    input  logic                  ovf_clr,
    output logic                  ovf,
    output logic                  auth_ok,
    output logic                  auth_fail
);
    dec_t          dec_c;
    logic          push_c, pop_c, wr_en_c, full_c;
    logic [TW+1:0] head_c;
    logic          ovf_q, ovf_d;

    assign dec_c   = decode_op(bus.core_opmode[3:0]);
    assign push_c  = bus.core_valid && dec_c.valid;
    assign pop_c   = bus.out_valid && bus.out_ready;
    assign wr_en_c = push_c && (!full_c || pop_c);

    xoodyak_resp_fifo #(
        .DEPTH (DEPTH),
        .EW    (TW + 2)
    ) u_fifo (
        .eph1     (eph1),
        .reset    (reset),
        .wr_en    (wr_en_c),
        .wr_data  ({dec_c.kind, bus.core_text}),
        .rd_en    (pop_c),
        .full_c   (full_c),
        .rd_valid (bus.out_valid),
        .rd_data  (head_c)
    );

    assign bus.out_kind = head_c[TW+1:TW];
    assign bus.out_data = head_c[TW-1:0];

    // A new overflow wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_c && full_c && !pop_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

`ifdef XOOD_RESP_TAGCHK_EN
    tstate_t          st_q, st_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             ok_q, ok_d, fail_q, fail_d;
    logic             tag_push_c;
    logic             unused_op;

    // Every TAG result is compared, including ones the FIFO drops.
    assign tag_push_c = bus.core_valid && (bus.core_opmode[3:0] == OP_SQUEEZE);
    assign unused_op  = bus.core_opmode[4];

    always_comb begin
        st_d   = st_q;
        tag_d  = tag_q;
        ok_d   = 1'b0;
        fail_d = 1'b0;
        case (st_q)
            T_IDLE: begin
                if (tag_load) begin
                    st_d  = T_ARMED;
                    tag_d = tag_exp;
                end
            end
            T_ARMED: begin
                if (tag_push_c) begin
                    if (bus.core_text[TW-1 -: TAG_W] == tag_q) begin
                        ok_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                    st_d = T_DONE;
                end else if (tag_load) begin
                    tag_d = tag_exp;
                end
            end
            T_DONE:  st_d = T_IDLE;
            default: st_d = T_IDLE;
        endcase
    end

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            st_q   <= T_IDLE;
            tag_q  <= '0;
            ok_q   <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            tag_q  <= tag_d;
            ok_q   <= ok_d;
            fail_q <= fail_d;
        end
    end

    assign auth_ok   = ok_q;
    assign auth_fail = fail_q;
`else
    logic unused_tag;
    assign unused_tag = ^{tag_exp, tag_load, bus.core_opmode[4]};
    assign auth_ok    = 1'b0;
    assign auth_fail  = 1'b0;
`endif

endmodule

// File: tb/tb_xoodyak_resp_collect.sv
// Directed bench for xoodyak_resp_collect with a queue-based reference model.
module tb_xoodyak_resp_collect;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 192;
    localparam logic [TW-1:0] TEXT1 = 192'h87a06d5561b0d87c20a12db5d3478325f1e2d3c4b5a60e30;
    localparam logic [127:0]  TAG1  = 128'h87a06d5561b0d87c20a12db5d3478325;
`ifdef XOOD_RESP_TAGCHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic         eph1 = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] tag_exp = '0;
    logic         tag_load = 1'b0;
    logic         ovf_clr = 1'b0;
    logic         ovf, auth_ok, auth_fail;

    xoodyak_resp_collect_if #(.TW(TW)) bus();

    xoodyak_resp_collect #(.DEPTH(DEPTH), .TW(TW)) dut (
        .eph1      (eph1),
        .reset     (reset),
        .bus       (bus),
        .tag_exp   (tag_exp),
        .tag_load  (tag_load),
        .ovf_clr   (ovf_clr),
        .ovf       (ovf),
        .auth_ok   (auth_ok),
        .auth_fail (auth_fail)
    );

    always #5 eph1 = ~eph1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted results plus flag bits.
    typedef struct packed {
        logic [1:0]    kind;
        logic [TW-1:0] data;
    } ent_t;

    ent_t         mq[$];
    logic         m_ovf = 1'b0, m_ok = 1'b0, m_fail = 1'b0, m_armed = 1'b0, m_done = 1'b0;
    logic [127:0] m_tag = '0;
    int           m_k;
    logic         m_pop, m_full, m_tagpush;

    function automatic int kind_of(input logic [3:0] op);
        case (op)
            4'd4, 4'd5: return 0;
            4'd6:       return 1;
            4'd8:       return 2;
            default:    return -1;
        endcase
    endfunction

    always @(posedge eph1 or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0; m_ok = 1'b0; m_fail = 1'b0;
            m_armed = 1'b0; m_done = 1'b0; m_tag = '0;
        end else begin
            m_k       = kind_of(bus.core_opmode[3:0]);
            m_pop     = (mq.size() != 0) && bus.out_ready;
            m_full    = (mq.size() == int'(DEPTH));
            m_tagpush = bus.core_valid && (m_k == 1);
            m_ok = 1'b0; m_fail = 1'b0;
            if (CHK) begin
                if (m_done) begin
                    m_done = 1'b0;
                end else if (m_armed) begin
                    if (m_tagpush) begin
                        m_ok    = (bus.core_text[191:64] == m_tag);
                        m_fail  = !m_ok;
                        m_armed = 1'b0;
                        m_done  = 1'b1;
                    end else if (tag_load) begin
                        m_tag = tag_exp;
                    end
                end else if (tag_load) begin
                    m_armed = 1'b1;
                    m_tag   = tag_exp;
                end
            end
            if (ovf_clr) m_ovf = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (bus.core_valid && m_k >= 0) begin
                if (!m_full || m_pop) mq.push_back('{kind: 2'(m_k), data: bus.core_text});
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge eph1) begin
        chk("out_valid", 200'(bus.out_valid), 200'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_kind", 200'(bus.out_kind), 200'(mq[0].kind));
            chk("out_data", 200'(bus.out_data), 200'(mq[0].data));
        end
        chk("ovf", 200'(ovf), 200'(m_ovf));
        chk("auth_ok", 200'(auth_ok), 200'(m_ok));
        chk("auth_fail", 200'(auth_fail), 200'(m_fail));
        chk("auth_excl", 200'(auth_ok & auth_fail), 200'(0));
    end

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    task automatic push(input logic [4:0] op, input logic [TW-1:0] txt);
        bus.core_valid  = 1'b1;
        bus.core_opmode = op;
        bus.core_text   = txt;
        tick();
        bus.core_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [TW-1:0] dv [5];
    logic [1:0]    kexp [4];
    logic [4:0]    ops [5];
    logic [TW-1:0] bad;
    int            n;

    initial begin
        bus.core_valid = 1'b0; bus.core_opmode = '0; bus.core_text = '0; bus.out_ready = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge eph1);
        @(negedge eph1);
        chk("rst_out_valid", 200'(bus.out_valid), 200'(0));
        chk("rst_out_data", 200'(bus.out_data), 200'(0));
        chk("rst_out_kind", 200'(bus.out_kind), 200'(0));
        chk("rst_ovf", 200'(ovf), 200'(0));
        chk("rst_auth", 200'({auth_ok, auth_fail}), 200'(0));
        tick();
        reset = 1'b0;
        tick();

        // Single TEXT result with host ready.
        bus.out_ready = 1'b1;
        push(5'd4, TEXT1);
        @(negedge eph1);
        chk("single_valid", 200'(bus.out_valid), 200'(1));
        chk("single_kind", 200'(bus.out_kind), 200'(0));
        chk("single_data", 200'(bus.out_data), 200'(TEXT1));
        tick();
        @(negedge eph1);
        chk("single_empty", 200'(bus.out_valid), 200'(0));

        // Overflow: five pushes into a four-deep FIFO.
        ops[0] = 5'd4; ops[1] = 5'd5; ops[2] = 5'd6; ops[3] = 5'd8; ops[4] = 5'd4;
        kexp[0] = 2'd0; kexp[1] = 2'd0; kexp[2] = 2'd1; kexp[3] = 2'd2;
        for (int i = 0; i < 5; i++) dv[i] = TEXT1 ^ TW'(i * 32'h1111 + 1);
        bus.out_ready = 1'b0;
        @(negedge eph1);
        for (int i = 0; i < 5; i++) push(ops[i], dv[i]);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge eph1);
            if (k == 0) chk("ovf_set", 200'(ovf), 200'(1));
            chk("drain_kind", 200'(bus.out_kind), 200'(kexp[k]));
            chk("drain_data", 200'(bus.out_data), 200'(dv[k]));
        end
        @(negedge eph1);
        chk("drain_empty", 200'(bus.out_valid), 200'(0));
        chk("ovf_sticky", 200'(ovf), 200'(1));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge eph1);
        chk("ovf_cleared", 200'(ovf), 200'(0));

        // Full FIFO with simultaneous pop and push.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(5'd4, dv[i]);
        bus.out_ready = 1'b1;
        push(5'd5, TEXT1);
        bus.out_ready = 1'b1;
        @(negedge eph1);
        chk("fullpp_ovf", 200'(ovf), 200'(0));
        chk("fullpp_head", 200'(bus.out_data), 200'(dv[1]));
        n = 1;
        repeat (5) begin
            @(negedge eph1);
            if (bus.out_valid) n++;
        end
        chk("fullpp_occupancy", 200'(n), 200'(4));

        // Tag check: matching, then one bit flipped, then load+push together.
        tag_exp = TAG1;
        tag_load = 1'b1;
        tick();
        tag_load = 1'b0;
        push(5'd6, TEXT1);
        @(negedge eph1);
        chk("tag_ok", 200'(auth_ok), 200'(CHK));
        chk("tag_ok_nofail", 200'(auth_fail), 200'(0));
        chk("tag_kind", 200'(bus.out_kind), 200'(1));
        tick();
        @(negedge eph1);
        chk("tag_ok_pulse", 200'(auth_ok), 200'(0));
        bad = TEXT1;
        bad[100] = ~bad[100];
        tag_load = 1'b1;
        tick();
        tag_load = 1'b0;
        push(5'd6, bad);
        @(negedge eph1);
        chk("tag_fail", 200'(auth_fail), 200'(CHK));
        chk("tag_fail_nook", 200'(auth_ok), 200'(0));
        tick();
        tick();
        tag_load = 1'b1;
        push(5'd6, TEXT1);
        tag_load = 1'b0;
        @(negedge eph1);
        chk("arm_only", 200'({auth_ok, auth_fail}), 200'(0));
        push(5'd6, TEXT1);
        @(negedge eph1);
        chk("arm_then_ok", 200'(auth_ok), 200'(CHK));
        tick();
        tick();

        // Undecoded opmodes, then reset with entries queued and a tag armed.
        bus.out_ready = 1'b0;
        push(5'd3, TEXT1);
        push(5'd9, TEXT1);
        @(negedge eph1);
        chk("bad_op_empty", 200'(bus.out_valid), 200'(0));
        chk("bad_op_ovf", 200'(ovf), 200'(0));
        for (int i = 0; i < 3; i++) push(5'd4, dv[i]);
        tag_load = 1'b1;
        tick();
        tag_load = 1'b0;
        @(negedge eph1);
        chk("pre_reset_valid", 200'(bus.out_valid), 200'(1));
        tick();
        reset = 1'b1;
        #2;
        chk("reset_async_valid", 200'(bus.out_valid), 200'(0));
        chk("reset_async_data", 200'(bus.out_data), 200'(0));
        tick();
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        push(5'd6, TEXT1);
        @(negedge eph1);
        chk("post_reset_valid", 200'(bus.out_valid), 200'(1));
        chk("post_reset_kind", 200'(bus.out_kind), 200'(1));
        chk("post_reset_noauth", 200'({auth_ok, auth_fail}), 200'(0));
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
